// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between the integer and FPU MEM stages:
// round-robin arbitration, registered port drive and tagged read-data return.
module dmem_port_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          int_req,
  input  logic          int_we,
  input  logic [AW-1:0] int_addr,
  input  logic [31:0]   int_wdata,
  input  logic          int_flush,
  output logic          int_gnt,
  output logic          int_stall,
  output logic          int_rvalid,
  output logic [31:0]   int_rdata,
  input  logic          fp_req,
  input  logic          fp_we,
  input  logic [AW-1:0] fp_addr,
  input  logic [31:0]   fp_wdata,
  output logic          fp_gnt,
  output logic          fp_stall,
  output logic          fp_rvalid,
  output logic [31:0]   fp_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          err_misaligned,
  output logic          err_src
);

  localparam int unsigned DW = 32;
  localparam int unsigned TD = MEM_LAT + 1;

  logic          last_grant_q, last_grant_d;  // 1 = FPU won last
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          err_mis_q, err_mis_d;
  logic          err_src_q, err_src_d;
  logic [TD-1:0] tag_valid_q, tag_valid_d;
  logic [TD-1:0] tag_src_q, tag_src_d;
  logic [TD-1:0] tag_err_q, tag_err_d;

  logic          int_ok, fp_ok, any_gnt, misaligned;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [TD-1:0] kill_vec;

  // Arbitration: flush blocks integer, conflicts alternate; nothing granted in reset
  always_comb begin
    int_ok    = rst & int_req & ~int_flush;
    fp_ok     = rst & fp_req;
    int_gnt   = int_ok & (~fp_ok | last_grant_q);
    fp_gnt    = fp_ok & ~int_gnt;
    int_stall = rst & int_req & ~int_gnt;
    fp_stall  = rst & fp_req & ~fp_gnt;
    any_gnt   = int_gnt | fp_gnt;
    sel_we    = fp_gnt ? fp_we    : int_we;
    sel_addr  = fp_gnt ? fp_addr  : int_addr;
    sel_wdata = fp_gnt ? fp_wdata : int_wdata;
    misaligned = any_gnt & (sel_addr[1:0] != 2'b00);
  end

  // Next-state for port registers, error pulse and return-tag pipeline
  always_comb begin
    last_grant_d = any_gnt ? fp_gnt : last_grant_q;
    mem_en_d     = any_gnt & ~misaligned;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if (mem_en_d) begin
      mem_we_d    = sel_we;
      mem_addr_d  = {sel_addr[AW-1:2], 2'b00};
      mem_wdata_d = sel_wdata;
    end
    err_mis_d = misaligned;
    err_src_d = misaligned ? fp_gnt : err_src_q;
    // A flush drops integer tags as they advance; FPU tags pass untouched
    kill_vec    = {TD{int_flush}} & ~tag_src_q;
    tag_valid_d = {tag_valid_q[TD-2:0] & ~kill_vec[TD-2:0], any_gnt & ~sel_we};
    tag_src_d   = {tag_src_q[TD-2:0], fp_gnt};
    tag_err_d   = {tag_err_q[TD-2:0], misaligned};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant_q <= 1'b1;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      err_mis_q    <= 1'b0;
      err_src_q    <= 1'b0;
      tag_valid_q  <= '0;
      tag_src_q    <= '0;
      tag_err_q    <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      err_mis_q    <= err_mis_d;
      err_src_q    <= err_src_d;
      tag_valid_q  <= tag_valid_d;
      tag_src_q    <= tag_src_d;
      tag_err_q    <= tag_err_d;
    end
  end

  // Return routing: the oldest tag lines up with memory data; errored loads return 0
  always_comb begin
    int_rvalid = tag_valid_q[TD-1] & ~tag_src_q[TD-1];
    fp_rvalid  = tag_valid_q[TD-1] &  tag_src_q[TD-1];
    int_rdata  = (int_rvalid & ~tag_err_q[TD-1]) ? mem_rdata : '0;
    fp_rdata   = (fp_rvalid  & ~tag_err_q[TD-1]) ? mem_rdata : '0;
  end

  assign mem_en         = mem_en_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign err_misaligned = err_mis_q;
  assign err_src        = err_src_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a read-return scoreboard and a
// latency-accurate memory model.
module tb_dmem_port_arbiter;

  localparam int unsigned MEM_LAT = 2;
  localparam int unsigned AW      = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          int_req = 1'b0, int_we = 1'b0, int_flush = 1'b0;
  logic [AW-1:0] int_addr = '0;
  logic [31:0]   int_wdata = '0;
  logic          fp_req = 1'b0, fp_we = 1'b0;
  logic [AW-1:0] fp_addr = '0;
  logic [31:0]   fp_wdata = '0;
  logic          int_gnt, int_stall, int_rvalid, fp_gnt, fp_stall, fp_rvalid;
  logic [31:0]   int_rdata, fp_rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_we, err_misaligned, err_src;
  logic [AW-1:0] mem_addr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int          cyc;
    logic        src;
    logic [31:0] data;
  } ret_t;
  ret_t sb[$];

  dmem_port_arbiter #(.MEM_LAT(MEM_LAT), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .int_req(int_req), .int_we(int_we), .int_addr(int_addr), .int_wdata(int_wdata),
    .int_flush(int_flush), .int_gnt(int_gnt), .int_stall(int_stall),
    .int_rvalid(int_rvalid), .int_rdata(int_rdata),
    .fp_req(fp_req), .fp_we(fp_we), .fp_addr(fp_addr), .fp_wdata(fp_wdata),
    .fp_gnt(fp_gnt), .fp_stall(fp_stall), .fp_rvalid(fp_rvalid), .fp_rdata(fp_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .err_misaligned(err_misaligned), .err_src(err_src)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
  endfunction

  // Memory model: data for a read issued in cycle k appears in cycle k+MEM_LAT
  logic        rd_v [MEM_LAT];
  logic [31:0] rd_a [MEM_LAT];
  initial for (int i = 0; i < int'(MEM_LAT); i++) begin rd_v[i] = 1'b0; rd_a[i] = '0; end
  always @(posedge clk) begin
    rd_v[0] <= mem_en & ~mem_we;
    rd_a[0] <= mem_addr;
    for (int i = 1; i < int'(MEM_LAT); i++) begin
      rd_v[i] <= rd_v[i-1];
      rd_a[i] <= rd_a[i-1];
    end
  end
  assign mem_rdata = (rd_v[MEM_LAT-1] === 1'b1) ? mem_val(rd_a[MEM_LAT-1]) : 32'hBAD0BAD0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_ret();
    logic        exp_iv, exp_fv;
    logic [31:0] exp_id, exp_fd;
    ret_t        e;
    exp_iv = 1'b0; exp_fv = 1'b0; exp_id = '0; exp_fd = '0;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      if (e.src) begin exp_fv = 1'b1; exp_fd = e.data; end
      else       begin exp_iv = 1'b1; exp_id = e.data; end
    end
    chk("int_rvalid", 32'(int_rvalid), 32'(exp_iv));
    chk("int_rdata",  int_rdata, exp_id);
    chk("fp_rvalid",  32'(fp_rvalid), 32'(exp_fv));
    chk("fp_rdata",   fp_rdata, exp_fd);
  endtask

  task automatic settle();
    @(negedge clk);
    check_ret();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    int_req = 1'b0; fp_req = 1'b0; int_flush = 1'b0;
    repeat (n) begin adv(); settle(); end
  endtask

  task automatic push(input int c, input logic src, input logic [31:0] d);
    ret_t e;
    e.cyc = c; e.src = src; e.data = d;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    int_req = 1'b0; fp_req = 1'b0; int_flush = 1'b0;
    rst = 1'b0;
    sb.delete();
    settle();
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_err", 32'(err_misaligned), 32'h0);
    chk("rst_err_src", 32'(err_src), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Single aligned integer load
    do_reset();
    int_req = 1'b1; int_we = 1'b0; int_addr = 32'h100;
    settle();
    chk("t1_int_gnt", 32'(int_gnt), 32'h1);
    chk("t1_fp_gnt", 32'(fp_gnt), 32'h0);
    push(3, 1'b0, 32'hDEADBEEF);
    adv(); int_req = 1'b0; settle();
    chk("t1_mem_en", 32'(mem_en), 32'h1);
    chk("t1_mem_we", 32'(mem_we), 32'h0);
    chk("t1_mem_addr", mem_addr, 32'h100);
    adv(); settle();
    chk("t1_mem_en_off", 32'(mem_en), 32'h0);
    idle(4);

    // Round-robin under sustained conflict
    do_reset();
    int_req = 1'b1; int_we = 1'b1; int_addr = 32'h400; int_wdata = 32'h11111111;
    fp_req  = 1'b1; fp_we  = 1'b1; fp_addr  = 32'h500; fp_wdata  = 32'h22222222;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) adv();
      settle();
      chk("t2_int_gnt",   32'(int_gnt),   32'(i % 2 == 0));
      chk("t2_fp_gnt",    32'(fp_gnt),    32'(i % 2 == 1));
      chk("t2_int_stall", 32'(int_stall), 32'(i % 2 == 1));
      chk("t2_fp_stall",  32'(fp_stall),  32'(i % 2 == 0));
      if (i > 0) chk("t2_mem_addr", mem_addr, (i % 2 == 1) ? 32'h400 : 32'h500);
    end
    adv(); int_req = 1'b0; fp_req = 1'b0; settle();
    chk("t2_mem_addr_last", mem_addr, 32'h500);
    chk("t2_mem_wdata_last", mem_wdata, 32'h22222222);
    idle(4);

    // FPU store loses to integer load, then issues
    do_reset();
    int_req = 1'b1; int_we = 1'b0; int_addr = 32'h104;
    fp_req  = 1'b1; fp_we  = 1'b1; fp_addr  = 32'h200; fp_wdata = 32'h3F800000;
    settle();
    chk("t3_int_gnt", 32'(int_gnt), 32'h1);
    chk("t3_fp_stall", 32'(fp_stall), 32'h1);
    push(3, 1'b0, mem_val(32'h104));
    adv(); int_req = 1'b0; settle();
    chk("t3_fp_gnt", 32'(fp_gnt), 32'h1);
    chk("t3_mem_we0", 32'(mem_we), 32'h0);
    chk("t3_mem_addr0", mem_addr, 32'h104);
    adv(); fp_req = 1'b0; settle();
    chk("t3_mem_en1", 32'(mem_en), 32'h1);
    chk("t3_mem_we1", 32'(mem_we), 32'h1);
    chk("t3_mem_addr1", mem_addr, 32'h200);
    chk("t3_mem_wdata1", mem_wdata, 32'h3F800000);
    idle(5);

    // Misaligned integer load, then misaligned FPU store
    do_reset();
    int_req = 1'b1; int_we = 1'b0; int_addr = 32'h102;
    settle();
    chk("t4_int_gnt", 32'(int_gnt), 32'h1);
    push(3, 1'b0, 32'h0);
    adv(); int_req = 1'b0; settle();
    chk("t4_err", 32'(err_misaligned), 32'h1);
    chk("t4_err_src", 32'(err_src), 32'h0);
    chk("t4_mem_en", 32'(mem_en), 32'h0);
    adv(); settle();
    chk("t4_err_pulse", 32'(err_misaligned), 32'h0);
    adv(); settle();
    adv(); fp_req = 1'b1; fp_we = 1'b1; fp_addr = 32'h203; settle();
    chk("t4_fp_gnt", 32'(fp_gnt), 32'h1);
    adv(); fp_req = 1'b0; settle();
    chk("t4_fp_err", 32'(err_misaligned), 32'h1);
    chk("t4_fp_err_src", 32'(err_src), 32'h1);
    chk("t4_fp_mem_en", 32'(mem_en), 32'h0);
    idle(4);

    // Flush kills an in-flight integer load but not the FPU load behind it
    do_reset();
    int_req = 1'b1; int_we = 1'b0; int_addr = 32'h100;
    settle();
    chk("t5_int_gnt0", 32'(int_gnt), 32'h1);
    adv(); int_req = 1'b0; fp_req = 1'b1; fp_we = 1'b0; fp_addr = 32'h300; settle();
    chk("t5_fp_gnt", 32'(fp_gnt), 32'h1);
    push(4, 1'b1, mem_val(32'h300));
    adv(); fp_req = 1'b0; int_flush = 1'b1; int_req = 1'b1; int_addr = 32'h108; settle();
    chk("t5_flush_gnt", 32'(int_gnt), 32'h0);
    chk("t5_flush_stall", 32'(int_stall), 32'h1);
    adv(); int_flush = 1'b0; settle();
    chk("t5_int_gnt3", 32'(int_gnt), 32'h1);
    push(6, 1'b0, mem_val(32'h108));
    adv(); int_req = 1'b0; settle();
    idle(5);

    // Reset in the middle of back-to-back loads
    do_reset();
    int_req = 1'b1; int_we = 1'b0; int_addr = 32'h100;
    settle();
    chk("t6_gnt0", 32'(int_gnt), 32'h1);
    adv(); int_addr = 32'h104; settle();
    chk("t6_gnt1", 32'(int_gnt), 32'h1);
    adv(); int_addr = 32'h108; rst = 1'b0; settle();
    chk("t6_rst_gnt", 32'(int_gnt), 32'h0);
    chk("t6_rst_stall", 32'(int_stall), 32'h0);
    chk("t6_rst_mem_en", 32'(mem_en), 32'h0);
    chk("t6_rst_mem_addr", mem_addr, 32'h0);
    chk("t6_rst_err", 32'(err_misaligned), 32'h0);
    adv(); int_req = 1'b0; settle();
    adv(); rst = 1'b1; settle();
    idle(3);
    adv();
    int_req = 1'b1; int_we = 1'b1; int_addr = 32'h600; int_wdata = 32'h33333333;
    fp_req  = 1'b1; fp_we  = 1'b1; fp_addr  = 32'h700; fp_wdata  = 32'h44444444;
    settle();
    chk("t6_post_int_gnt", 32'(int_gnt), 32'h1);
    chk("t6_post_fp_stall", 32'(fp_stall), 32'h1);
    adv(); int_req = 1'b0; settle();
    chk("t6_post_fp_gnt", 32'(fp_gnt), 32'h1);
    chk("t6_post_mem_addr", mem_addr, 32'h600);
    idle(4);

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
